// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch program-counter controller.
// It sequences the fetch address and takes jal/jalr/taken-branch redirects
// from EX. Each redirect squashes fetch for FLUSH_CYCLES cycles.
// Misaligned targets raise a one-cycle error and are not taken.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  operation,
  input  logic        ex_valid,
  input  logic        br_taken,
  input  logic [31:0] jmp_to,
  input  logic        if_ready,
  input  logic        stall_in,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        flush,
  output logic        misalign_err,
  output logic [15:0] redirect_cnt
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic        flush_q, flush_d;
  logic        mis_q, mis_d;

  logic        redir_req;
  logic [31:0] eff_tgt;
  logic        tgt_ok;

  // Redirect count never wraps; it sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Decode the EX instruction into a redirect request and its effective target
  always_comb begin
    redir_req = ex_valid && ((operation == OP_JAL) || (operation == OP_JALR) ||
                             ((operation == OP_BRANCH) && br_taken));
    eff_tgt   = (operation == OP_JALR) ? {jmp_to[31:1], 1'b0} : jmp_to;
    tgt_ok    = (eff_tgt[1:0] == 2'b00);
  end

  // State register; reset wins over everything, including mid-FLUSH
  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // Next-state logic: BOOT lasts one cycle; only an aligned redirect in RUN enters FLUSH
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (redir_req && tgt_ok) state_d = FLUSH;
      FLUSH:   if (fcnt_q <= 3'd1) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Output logic: next values of every registered output and the flush counter
  always_comb begin
    pc_d   = pc_q;
    fcnt_d = fcnt_q;
    cnt_d  = cnt_q;
    mis_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (redir_req && tgt_ok) begin
          pc_d   = eff_tgt;
          fcnt_d = 3'(FLUSH_CYCLES);
          cnt_d  = sat_inc16(cnt_q);
        end else begin
          // A misaligned request is reported but otherwise behaves as no redirect
          mis_d = redir_req;
          if (if_ready && !stall_in) pc_d = pc_q + 32'd4;
        end
      end
      FLUSH:   fcnt_d = fcnt_q - 3'd1;
      default: ;
    endcase
    vld_d   = (state_d == RUN);
    flush_d = (state_d == FLUSH);
  end

  // Output and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      fcnt_q  <= 3'd0;
      cnt_q   <= 16'd0;
      vld_q   <= 1'b0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fcnt_q  <= fcnt_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_out       = pc_q;
  assign pc_valid     = vld_q;
  assign flush        = flush_q;
  assign misalign_err = mis_q;
  assign redirect_cnt = cnt_q;

endmodule
